uart_packet_rx: RTL and testbench

Receive-side counterpart of the UART packetizer transmit path. Deserialises the UART line (8N1, LSB first) and de-frames packets of the form HEADER, LEN, LEN payload bytes, CHK, where CHK = XOR of LEN and all payload bytes. Payload bytes stream out with a valid strobe as they arrive. A packet-end strobe reports whether the packet passed checksum and framing.

---
 rtl/uart_packet_rx_if.sv | 31 +++
 rtl/uart_packet_rx.sv | 195 +++++++++++++++++++
 tb/tb_uart_packet_rx.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_packet_rx_if.sv
// Line-side and stream-side signals of the UART packet receiver.
// The master drives the line; the slave (receiver) drives the stream outputs.
interface uart_packet_rx_if;
    logic       serial_in;
    logic [7:0] data_out;
    logic       data_out_valid;
    logic       pkt_done;
    logic       pkt_err;
    logic       frame_err;
    logic       rx_busy;

    modport master (
        output serial_in,
        input  data_out,
        input  data_out_valid,
        input  pkt_done,
        input  pkt_err,
        input  frame_err,
        input  rx_busy
    );

    modport slave (
        input  serial_in,
        output data_out,
        output data_out_valid,
        output pkt_done,
        output pkt_err,
        output frame_err,
        output rx_busy
    );
endinterface

// File: rtl/uart_packet_rx.sv
// UART 8N1 byte receiver feeding a HEADER/LEN/payload/CHK packet de-framer.
// Payload streams out as it arrives; packet end reports checksum/framing status.
module uart_packet_rx #(
    parameter int         CLK_FREQ     = 50_000_000,
    parameter int         BAUD_RATE    = 115200,
    parameter logic [7:0] HEADER       = 8'hA5,
    parameter int         MAX_LEN      = 16,
    parameter int         TIMEOUT_BITS = 20
) (
    input  logic           clk,
    input  logic           rst,
    uart_packet_rx_if.slave bus
);

    localparam int CPB    = CLK_FREQ / BAUD_RATE;
    localparam int HALF   = CPB / 2;
    localparam int TW     = $clog2(CPB + 1);
    localparam int TO_CYC = TIMEOUT_BITS * CPB;
    localparam int OW     = $clog2(TO_CYC + 1);

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} r_state_e;
    typedef enum logic [1:0] {P_HUNT, P_LEN, P_PAYLOAD, P_CHK} p_state_e;

    logic          sync_q, rs_q;
    r_state_e      r_state_q, r_state_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          byte_rdy, stop_bad;

    p_state_e      p_state_q, p_state_d;
    logic [7:0]    rem_q, rem_d;
    logic [7:0]    chk_q, chk_d;
    logic [OW-1:0] to_q, to_d;
    logic          abort;

    logic [7:0]    data_out_q, data_out_d;
    logic          valid_q, valid_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          fe_q, fe_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= 1'b1;
            rs_q   <= 1'b1;
        end else begin
            sync_q <= bus.serial_in;
            rs_q   <= sync_q;
        end
    end

    always_comb begin
        r_state_d = r_state_q;
        tmr_d     = tmr_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        byte_rdy  = 1'b0;
        stop_bad  = 1'b0;
        unique case (r_state_q)
            R_IDLE: begin
                if (!rs_q) begin
                    r_state_d = R_START;
                    tmr_d     = '0;
                end
            end
            R_START: begin
                if (tmr_q == TW'(HALF - 1)) begin
                    tmr_d = '0;
                    idx_d = '0;
                    // a start bit gone high by mid-bit was line noise
                    r_state_d = rs_q ? R_IDLE : R_DATA;
                end else begin
                    tmr_d = tmr_q + TW'(1);
                end
            end
            R_DATA: begin
                if (tmr_q == TW'(CPB - 1)) begin
                    tmr_d          = '0;
                    shift_d[idx_q] = rs_q;
                    if (idx_q == 3'd7) r_state_d = R_STOP;
                    else               idx_d     = idx_q + 3'd1;
                end else begin
                    tmr_d = tmr_q + TW'(1);
                end
            end
            R_STOP: begin
                if (tmr_q == TW'(CPB - 1)) begin
                    tmr_d     = '0;
                    byte_rdy  = rs_q;
                    stop_bad  = !rs_q;
                    r_state_d = R_IDLE;
                end else begin
                    tmr_d = tmr_q + TW'(1);
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_comb begin
        p_state_d  = p_state_q;
        rem_d      = rem_q;
        chk_d      = chk_q;
        to_d       = to_q;
        data_out_d = data_out_q;
        valid_d    = 1'b0;
        done_d     = 1'b0;
        err_d      = err_q;
        fe_d       = stop_bad;
        abort      = 1'b0;
        if (p_state_q == P_HUNT) begin
            to_d = '0;
            if (byte_rdy && shift_q == HEADER) p_state_d = P_LEN;
        end else if (stop_bad) begin
            abort = 1'b1;
        end else if (byte_rdy) begin
            // a byte arriving on the expiry cycle still counts
            to_d = '0;
            unique case (p_state_q)
                P_LEN: begin
                    if (shift_q != 8'd0 && shift_q <= 8'(MAX_LEN)) begin
                        rem_d     = shift_q;
                        chk_d     = shift_q;
                        p_state_d = P_PAYLOAD;
                    end else begin
                        abort = 1'b1;
                    end
                end
                P_PAYLOAD: begin
                    data_out_d = shift_q;
                    valid_d    = 1'b1;
                    chk_d      = chk_q ^ shift_q;
                    rem_d      = rem_q - 8'd1;
                    if (rem_q == 8'd1) p_state_d = P_CHK;
                end
                P_CHK: begin
                    done_d    = 1'b1;
                    err_d     = (shift_q != chk_q);
                    p_state_d = P_HUNT;
                end
                default: p_state_d = P_HUNT;
            endcase
        end else if (to_q == OW'(TO_CYC - 1)) begin
            abort = 1'b1;
        end else begin
            to_d = to_q + OW'(1);
        end
        if (abort) begin
            done_d    = 1'b1;
            err_d     = 1'b1;
            p_state_d = P_HUNT;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q  <= R_IDLE;
            tmr_q      <= '0;
            idx_q      <= '0;
            shift_q    <= '0;
            p_state_q  <= P_HUNT;
            rem_q      <= '0;
            chk_q      <= '0;
            to_q       <= '0;
            data_out_q <= '0;
            valid_q    <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            fe_q       <= 1'b0;
        end else begin
            r_state_q  <= r_state_d;
            tmr_q      <= tmr_d;
            idx_q      <= idx_d;
            shift_q    <= shift_d;
            p_state_q  <= p_state_d;
            rem_q      <= rem_d;
            chk_q      <= chk_d;
            to_q       <= to_d;
            data_out_q <= data_out_d;
            valid_q    <= valid_d;
            done_q     <= done_d;
            err_q      <= err_d;
            fe_q       <= fe_d;
        end
    end

    assign bus.data_out       = data_out_q;
    assign bus.data_out_valid = valid_q;
    assign bus.pkt_done       = done_q;
    assign bus.pkt_err        = err_q;
    assign bus.frame_err      = fe_q;
    assign bus.rx_busy        = (r_state_q != R_IDLE) || (p_state_q != P_HUNT);

endmodule

// File: tb/tb_uart_packet_rx.sv
// Bench for uart_packet_rx: fixed packet vectors, corner sequences
// and random packets checked against an intent-level packet model.
module tb_uart_packet_rx;

    localparam int CPB  = 10;
    localparam int MAXL = 16;

    typedef struct {
        int         n;
        logic [7:0] b [8];
        int         ne;
        logic [7:0] e [4];
        int         nd;
        int         err;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;

    logic [7:0] got_d [$];
    logic       got_e [$];
    int         fe_cnt = 0;
    int         overlap = 0;
    int         first_dov_cyc = -1;
    int         last_dov_cyc = 0;
    int         last_done_cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_packet_rx_if bus ();

    uart_packet_rx #(
        .CLK_FREQ    (1_000_000),
        .BAUD_RATE   (100_000),
        .HEADER      (8'hA5),
        .MAX_LEN     (MAXL),
        .TIMEOUT_BITS(20)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.data_out_valid) begin
                if (got_d.size() == 0) first_dov_cyc = cyc;
                got_d.push_back(bus.data_out);
                last_dov_cyc = cyc;
            end
            if (bus.pkt_done) begin
                got_e.push_back(bus.pkt_err);
                last_done_cyc = cyc;
            end
            if (bus.frame_err) fe_cnt++;
            if (bus.pkt_done && bus.data_out_valid) overlap++;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
                     name, act, act, exp, exp);
        end
    endtask

    task automatic send_bit(input logic v);
        bus.serial_in = v;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop);
        send_bit(1'b1);
    endtask

    task automatic idle(input int n);
        bus.serial_in = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_mon();
        got_d.delete();
        got_e.delete();
        fe_cnt = 0;
        overlap = 0;
        first_dov_cyc = -1;
    endtask

    task automatic check_pkt(input string tag, input logic [7:0] exp_d [$],
                             input int exp_nd, input int exp_err,
                             input int exp_fe);
        check({tag, ".ndata"}, got_d.size(), exp_d.size());
        for (int i = 0; i < exp_d.size(); i++)
            if (i < got_d.size())
                check($sformatf("%s.d%0d", tag, i), got_d[i], exp_d[i]);
        check({tag, ".ndone"}, got_e.size(), exp_nd);
        for (int i = 0; i < got_e.size(); i++)
            check($sformatf("%s.err%0d", tag, i), got_e[i], exp_err);
        check({tag, ".fe"}, fe_cnt, exp_fe);
        check({tag, ".overlap"}, overlap, 0);
    endtask

    vec_t       tbl [5];
    logic [7:0] exp_q [$];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{6, '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03, 0, 0},
                   3, '{8'h11, 8'h22, 8'h33, 0}, 1, 0};
        tbl[1] = '{5, '{8'hA5, 8'h02, 8'hAA, 8'h55, 8'h00, 0, 0, 0},
                   2, '{8'hAA, 8'h55, 0, 0}, 1, 1};
        tbl[2] = '{6, '{8'h00, 8'h7E, 8'hA5, 8'h01, 8'h5C, 8'h5D, 0, 0},
                   1, '{8'h5C, 0, 0, 0}, 1, 0};
        tbl[3] = '{2, '{8'hA5, 8'h00, 0, 0, 0, 0, 0, 0},
                   0, '{0, 0, 0, 0}, 1, 1};
        tbl[4] = '{2, '{8'hA5, 8'h11, 0, 0, 0, 0, 0, 0},
                   0, '{0, 0, 0, 0}, 1, 1};

        bus.serial_in = 1'b1;
        rst = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst.data_out", bus.data_out, 0);
        check("rst.valid", bus.data_out_valid, 0);
        check("rst.done", bus.pkt_done, 0);
        check("rst.err", bus.pkt_err, 0);
        check("rst.fe", bus.frame_err, 0);
        check("rst.busy", bus.rx_busy, 0);

        for (int v = 0; v < 5; v++) begin
            clear_mon();
            for (int j = 0; j < tbl[v].n; j++) send_byte(tbl[v].b[j], 1'b1);
            idle(20);
            exp_q.delete();
            for (int j = 0; j < tbl[v].ne; j++) exp_q.push_back(tbl[v].e[j]);
            check_pkt($sformatf("vec%0d", v), exp_q, tbl[v].nd, tbl[v].err, 0);
        end

        // first payload byte appears one cycle after its stop-bit sample
        clear_mon();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h01, 1'b1);
        begin
            int fall_cyc;
            fall_cyc = cyc;
            send_byte(8'h3C, 1'b1);
            send_byte(8'h3D, 1'b1);
            idle(20);
            check("lat.cycles", first_dov_cyc - fall_cyc, CPB * 19 / 2 + 3);
        end
        exp_q = '{8'h3C};
        check_pkt("lat", exp_q, 1, 0, 0);

        clear_mon();
        bus.serial_in = 1'b0;
        repeat (3) @(negedge clk);
        idle(40);
        check("glitch.busy", bus.rx_busy, 0);
        exp_q.delete();
        check_pkt("glitch", exp_q, 0, 0, 0);

        clear_mon();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h01, 1'b0);
        idle(30);
        exp_q.delete();
        check_pkt("frame", exp_q, 1, 1, 1);

        clear_mon();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h04, 1'b1);
        send_byte(8'h01, 1'b1);
        check("tmo.busy", bus.rx_busy, 1);
        for (int i = 0; i < 400 && got_e.size() == 0; i++) @(negedge clk);
        check("tmo.delay", last_done_cyc - last_dov_cyc, 200);
        idle(5);
        check("tmo.err_held", bus.pkt_err, 1);
        exp_q = '{8'h01};
        check_pkt("tmo", exp_q, 1, 1, 0);

        clear_mon();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h03, 1'b1);
        send_byte(8'h44, 1'b1);
        bus.serial_in = 1'b0;
        repeat (25) @(negedge clk);
        rst = 1'b1;
        bus.serial_in = 1'b1;
        @(negedge clk);
        check("mrst.data_out", bus.data_out, 0);
        check("mrst.valid", bus.data_out_valid, 0);
        check("mrst.done", bus.pkt_done, 0);
        check("mrst.err", bus.pkt_err, 0);
        check("mrst.fe", bus.frame_err, 0);
        check("mrst.busy", bus.rx_busy, 0);
        @(negedge clk);
        rst = 1'b0;
        clear_mon();
        idle(30);
        send_byte(8'hA5, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'hC3, 1'b1);
        send_byte(8'h3C, 1'b1);
        send_byte(8'hFD, 1'b1);
        idle(20);
        exp_q = '{8'hC3, 8'h3C};
        check_pkt("mrst.after", exp_q, 1, 0, 0);

        // random packets: expectation follows from how each one was built
        for (int p = 0; p < 16; p++) begin
            logic [7:0] len;
            logic [7:0] chk;
            logic [7:0] jb;
            int         kind;
            int         bad;
            logic [7:0] pl [$];
            clear_mon();
            pl.delete();
            for (int j = 0; j < $urandom_range(0, 2); j++) begin
                do jb = 8'($urandom_range(0, 255)); while (jb == 8'hA5);
                send_byte(jb, 1'b1);
            end
            kind = $urandom_range(0, 7);
            send_byte(8'hA5, 1'b1);
            if (kind == 0) begin
                if ($urandom_range(0, 1) == 0) len = 8'h00;
                else len = 8'($urandom_range(MAXL + 1, 255));
                send_byte(len, 1'b1);
                bad = 1;
            end else begin
                len = 8'($urandom_range(1, MAXL));
                for (int j = 0; j < int'(len); j++)
                    pl.push_back(8'($urandom_range(0, 255)));
                chk = len;
                foreach (pl[j]) chk = chk ^ pl[j];
                bad = (kind == 1 || kind == 2) ? 1 : 0;
                if (bad == 1) chk = chk ^ 8'($urandom_range(1, 255));
                send_byte(len, 1'b1);
                foreach (pl[j]) send_byte(pl[j], 1'b1);
                send_byte(chk, 1'b1);
            end
            idle(20);
            check_pkt($sformatf("rnd%0d", p), pl, 1, bad, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
